// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: state type, default sizes and sizing helpers for seq_chunk_adder
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    function automatic int nchunk(int width, int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_add_chunk.sv
// add_chunk: CHUNK-bit ripple-carry slice built from fa1 cells, exposing the carry into its MSB
module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fa1 u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (sum[i]),
            .co(c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per cycle; SEQ_CHUNK_ADDER_OVF_EN adds the ovf output
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] s_chunk;
    logic             c_next, c_msb, last;

    assign last      = idx == IDX_W'(NCHUNK - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign cout      = carry;

    add_chunk #(.CHUNK(CHUNK)) u_add (
        .a       (a_r[idx*CHUNK +: CHUNK]),
        .b       (b_r[idx*CHUNK +: CHUNK]),
        .cin     (carry),
        .sum     (s_chunk),
        .cout    (c_next),
        .c_msb_in(c_msb)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*CHUNK +: CHUNK] <= s_chunk;
            carry                   <= c_next;
            idx                     <= idx + 1'b1;
        end
    end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (state == RUN && last)
            ovf <= c_msb ^ c_next;
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder at 64/8 and 32/32 (honours SEQ_CHUNK_ADDER_OVF_EN)
module tb_seq_chunk_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, r0, ci0 = 1'b0, sb0 = 1'b0, ov0, or0 = 1'b1, co0;
    logic [63:0] a0 = '0, b0 = '0, s0;
    logic        v1 = 1'b0, r1, ci1 = 1'b0, sb1 = 1'b0, ov1, or1 = 1'b1, co1;
    logic [31:0] a1 = '0, b1 = '0, s1;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic        ovf0, ovf1;
`endif

    int   errors = 0;
    int   checks = 0;
    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;

    seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) u0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0),
        .cin(ci0), .sub(sb0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf0)
`endif
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic signed [66:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w)) >>> (64 - w);
        return 67'(t);
    endfunction

    // Reference: plain integer arithmetic at width w, unsigned for sum/cout, signed for overflow
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s);
        logic [64:0]        u;
        logic signed [66:0] x, lim;
        res_t               r;
        u   = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b} + 65'(ci);
        r.s = u[63:0] & (~64'd0 >> (64 - w));
        r.c = s ? (a >= b) : u[w];
        x   = s ? sext(a, w) - sext(b, w) : sext(a, w) + sext(b, w) + 67'(ci);
        lim = 67'sd1 <<< (w - 1);
        r.o = (x >= lim) || (x < -lim);
        return r;
    endfunction

    task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic s);
        int n = 0;
        @(negedge clk);
        a0 = a; b0 = b; ci0 = ci; sb0 = s; v0 = 1'b1;
        while (!r0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept0", 64'(r0), 64'd1);
        q0.push_back(model(64, a, b, ci, s));
        @(posedge clk);
        #1 v0 = 1'b0;
    endtask

    task automatic done0;
        int n = 0;
        while (!ov0 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency0", 64'(n), 64'd8);
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
        int n = 0;
        @(negedge clk);
        a1 = a; b1 = b; ci1 = ci; sb1 = s; v1 = 1'b1;
        while (!r1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept1", 64'(r1), 64'd1);
        q1.push_back(model(32, 64'(a), 64'(b), ci, s));
        @(posedge clk);
        #1 v1 = 1'b0;
        n = 0;
        while (!ov1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency1", 64'(n), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && ov0 && or0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out0_unexpected: got sum %h with no pending operation", s0);
            end else begin
                e0 = q0.pop_front();
                chk("sum0", s0, e0.s);
                chk("cout0", 64'(co0), 64'(e0.c));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                chk("ovf0", 64'(ovf0), 64'(e0.o));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov1 && or1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out1_unexpected: got sum %h with no pending operation", s1);
            end else begin
                e1 = q1.pop_front();
                chk("sum1", 64'(s1), e1.s);
                chk("cout1", 64'(co1), 64'(e1.c));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                chk("ovf1", 64'(ovf1), 64'(e1.o));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] hs;
        logic        hc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready0", 64'(r0), 64'd1);
        chk("rst_out_valid0", 64'(ov0), 64'd0);
        chk("rst_sum0", s0, 64'd0);
        chk("rst_cout0", 64'(co0), 64'd0);
        chk("rst_in_ready1", 64'(r1), 64'd1);
        chk("rst_out_valid1", 64'(ov1), 64'd0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        chk("rst_ovf0", 64'(ovf0), 64'd0);
`endif
        reset = 1'b0;

        send0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); done0;
        send0(64'd5, 64'd7, 1'b0, 1'b1); done0;
        send0(64'd7, 64'd5, 1'b1, 1'b1); done0;
        send0(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0); done0;
        send0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); done0;
        send0(64'd1, 64'd1, 1'b0, 1'b0); done0;
        send0(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1); done0;

        send0(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0);
        or0 = 1'b0;
        done0;
        hs = s0;
        hc = co0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_sum", s0, hs);
            chk("hold_cout", 64'(co0), 64'(hc));
            chk("hold_valid", 64'(ov0), 64'd1);
            chk("hold_in_ready", 64'(r0), 64'd0);
            v0 = (i == 10);
            a0 = 64'h1111;
            b0 = 64'h2222;
        end
        v0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(r0), 64'd1);
        chk("release_valid", 64'(ov0), 64'd0);

        send0(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
        void'(q0.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_valid", 64'(ov0), 64'd0);
        chk("abort_sum", s0, 64'd0);
        chk("abort_in_ready", 64'(r0), 64'd1);
        send0(64'd1, 64'd1, 1'b0, 1'b0); done0;

        for (int i = 0; i < 30; i++) begin
            send0({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            or0 = $urandom_range(0, 2) != 0;
            done0;
            if (!or0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 or0 = 1'b1;
            end
        end

        send1(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send1(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send1(32'd3, 32'd9, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            send1($urandom, $urandom, 1'($urandom), 1'($urandom));

        repeat (5) @(posedge clk);
        #1;
        chk("drain0", 64'(q0.size()), 64'd0);
        chk("drain1", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
